// File: rtl/pll_reset_sequencer.sv
// pll_reset_sequencer: power-up sequencer for the SoC clock/reset generator.
// Enables per-domain PLLs one at a time, waits for a filtered lock on each,
// then releases the domain resets in index order. It watches lock while running.
// Optional feature macro: LOCK_LOSS_RECOVERY_EN. When it is defined, a lock loss
// restarts the whole sequence. When it is undefined, a lock loss raises a sticky fault.
module pll_reset_sequencer #(
  parameter int unsigned NUM_DOM       = 4,
  parameter int unsigned LOCK_TIMEOUT  = 4096,
  parameter int unsigned STABLE_CYCLES = 256,
  parameter int unsigned RST_GAP       = 16,
  parameter int unsigned CNT_W         = 16,
  localparam int unsigned IDX_W        = (NUM_DOM > 1) ? $clog2(NUM_DOM) : 1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [NUM_DOM-1:0] pll_locked,
  output logic [NUM_DOM-1:0] pll_en,
  output logic [NUM_DOM-1:0] domain_rst,
  output logic               all_ready,
  output logic               fault,
  output logic [IDX_W-1:0]   fault_idx,
  output logic [2:0]         state_o
);

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_PLL_ON    = 3'd1,
    S_WAIT_LOCK = 3'd2,
    S_STABLE    = 3'd3,
    S_RELEASE   = 3'd4,
    S_RUN       = 3'd5,
    S_FAULT     = 3'd6
  } state_e;

  localparam logic [IDX_W-1:0] LAST_IDX     = IDX_W'(NUM_DOM - 1);
  localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(LOCK_TIMEOUT - 1);
  localparam logic [CNT_W-1:0] STABLE_LAST  = CNT_W'(STABLE_CYCLES - 1);
  localparam logic [CNT_W-1:0] GAP_LAST     = CNT_W'(RST_GAP - 1);

  state_e               state_q, state_d;
  logic [IDX_W-1:0]     idx_q, idx_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [NUM_DOM-1:0]   pll_en_q, pll_en_d;
  logic [NUM_DOM-1:0]   domain_rst_q, domain_rst_d;
  logic                 all_ready_q, all_ready_d;
  logic                 fault_q, fault_d;
  logic [IDX_W-1:0]     fault_idx_q, fault_idx_d;
  logic [NUM_DOM-1:0]   lk_meta_q, lk_q;
  logic [NUM_DOM-1:0]   lost_vec;
  logic                 lock_lost;
  logic                 past_all;

  // Two-flop synchronizer for the asynchronous PLL lock inputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      lk_meta_q <= '0;
      lk_q      <= '0;
    end else begin
      lk_meta_q <= pll_locked;
      lk_q      <= lk_meta_q;
    end
  end

  // Lock loss: an enabled domain already sequenced past (or any domain once releasing/running).
  always_comb begin
    lost_vec = '0;
    past_all = (state_q == S_RELEASE) || (state_q == S_RUN);
    for (int unsigned i = 0; i < NUM_DOM; i++) begin
      if (pll_en_q[i] && !lk_q[i] && (past_all || (IDX_W'(i) < idx_q))) begin
        lost_vec[i] = 1'b1;
      end
    end
    lock_lost = |lost_vec;
  end

`ifdef LOCK_LOSS_RECOVERY_EN
  // Recovery restarts from domain 0, so the lost index is not recorded.
`else
  logic [IDX_W-1:0] lost_idx;

  // Lowest lost domain index, reported as the fault source.
  always_comb begin
    lost_idx = '0;
    for (int i = int'(NUM_DOM) - 1; i >= 0; i--) begin
      if (lost_vec[i]) begin
        lost_idx = IDX_W'(i);
      end
    end
  end
`endif

  // Next-state and registered-output logic; priority start=0 > lock loss > timeout > advance.
  always_comb begin
    state_d      = state_q;
    idx_d        = idx_q;
    cnt_d        = cnt_q;
    pll_en_d     = pll_en_q;
    domain_rst_d = domain_rst_q;
    fault_d      = fault_q;
    fault_idx_d  = fault_idx_q;

    if (!start) begin
      if (state_q != S_IDLE) begin
        state_d      = S_IDLE;
        idx_d        = '0;
        cnt_d        = '0;
        pll_en_d     = '0;
        domain_rst_d = '1;
        fault_d      = 1'b0;
        fault_idx_d  = '0;
      end
    end else if (lock_lost) begin
`ifdef LOCK_LOSS_RECOVERY_EN
      state_d      = S_PLL_ON;
      idx_d        = '0;
      cnt_d        = '0;
      pll_en_d     = '0;
      domain_rst_d = '1;
`else
      state_d      = S_FAULT;
      idx_d        = '0;
      cnt_d        = '0;
      pll_en_d     = '0;
      domain_rst_d = '1;
      fault_d      = 1'b1;
      fault_idx_d  = lost_idx;
`endif
    end else begin
      unique case (state_q)
        S_IDLE: begin
          state_d      = S_PLL_ON;
          idx_d        = '0;
          cnt_d        = '0;
          pll_en_d     = '0;
          domain_rst_d = '1;
        end
        S_PLL_ON: begin
          pll_en_d[idx_q] = 1'b1;
          cnt_d           = '0;
          state_d         = S_WAIT_LOCK;
        end
        S_WAIT_LOCK: begin
          if (lk_q[idx_q]) begin
            state_d = S_STABLE;
            cnt_d   = '0;
          end else if (cnt_q == TIMEOUT_LAST) begin
            state_d      = S_FAULT;
            cnt_d        = '0;
            idx_d        = '0;
            pll_en_d     = '0;
            domain_rst_d = '1;
            fault_d      = 1'b1;
            fault_idx_d  = idx_q;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
        S_STABLE: begin
          if (!lk_q[idx_q]) begin
            state_d = S_WAIT_LOCK;
            cnt_d   = '0;
          end else if (cnt_q == STABLE_LAST) begin
            cnt_d = '0;
            if (idx_q == LAST_IDX) begin
              idx_d           = '0;
              state_d         = S_RELEASE;
              domain_rst_d[0] = 1'b0;
            end else begin
              idx_d   = idx_q + IDX_W'(1);
              state_d = S_PLL_ON;
            end
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
        S_RELEASE: begin
          if (cnt_q == GAP_LAST) begin
            cnt_d = '0;
            if (idx_q == LAST_IDX) begin
              idx_d   = '0;
              state_d = S_RUN;
            end else begin
              idx_d               = idx_q + IDX_W'(1);
              domain_rst_d[idx_d] = 1'b0;
            end
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
        S_RUN: begin
          pll_en_d     = '1;
          domain_rst_d = '0;
        end
        S_FAULT: begin
          pll_en_d     = '0;
          domain_rst_d = '1;
          fault_d      = 1'b1;
        end
        default: begin
          state_d      = S_IDLE;
          idx_d        = '0;
          cnt_d        = '0;
          pll_en_d     = '0;
          domain_rst_d = '1;
        end
      endcase
    end

    all_ready_d = (state_d == S_RUN);
  end

  // State and output registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= S_IDLE;
      idx_q        <= '0;
      cnt_q        <= '0;
      pll_en_q     <= '0;
      domain_rst_q <= '1;
      all_ready_q  <= 1'b0;
      fault_q      <= 1'b0;
      fault_idx_q  <= '0;
    end else begin
      state_q      <= state_d;
      idx_q        <= idx_d;
      cnt_q        <= cnt_d;
      pll_en_q     <= pll_en_d;
      domain_rst_q <= domain_rst_d;
      all_ready_q  <= all_ready_d;
      fault_q      <= fault_d;
      fault_idx_q  <= fault_idx_d;
    end
  end

  assign pll_en     = pll_en_q;
  assign domain_rst = domain_rst_q;
  assign all_ready  = all_ready_q;
  assign fault      = fault_q;
  assign fault_idx  = fault_idx_q;
  assign state_o    = state_q;

endmodule

// File: tb/tb_pll_reset_sequencer.sv
// Bench for pll_reset_sequencer. The stimulus queues expected output snapshots.
// A monitor pops one snapshot and compares it each time the DUT outputs change.
module tb_pll_reset_sequencer;

  typedef struct packed {
    logic [2:0] st;
    logic [3:0] en;
    logic [3:0] dr;
    logic       ar;
    logic       f;
    logic [1:0] fi;
  } snap_t;

  typedef struct {
    snap_t s;
    int    cyc;   // expected cycle, -1 = any
    bit    wm;    // skip non-matching changes until this snapshot appears
    int    tag;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       start = 1'b0;
  logic [3:0] pll_locked = '0;
  logic [3:0] pll_en;
  logic [3:0] domain_rst;
  logic       all_ready;
  logic       fault;
  logic [1:0] fault_idx;
  logic [2:0] state_o;

  exp_t       q[$];
  int         checks = 0;
  int         failures = 0;
  int         cyc = 0;
  int         age[4];
  logic [3:0] kill = '0;

  pll_reset_sequencer #(
    .NUM_DOM(4), .LOCK_TIMEOUT(64), .STABLE_CYCLES(8), .RST_GAP(4), .CNT_W(16)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .pll_locked(pll_locked),
    .pll_en(pll_en), .domain_rst(domain_rst), .all_ready(all_ready),
    .fault(fault), .fault_idx(fault_idx), .state_o(state_o)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // PLL model: lock rises 10 cycles after enable; kill[i] forces lock low.
  initial for (int i = 0; i < 4; i++) age[i] = 0;
  always @(posedge clk) begin
    #1;
    for (int i = 0; i < 4; i++) begin
      if (!pll_en[i]) age[i] = 0;
      else if (age[i] < 1000) age[i] = age[i] + 1;
      pll_locked[i] = (age[i] > 10) && !kill[i];
    end
  end

  function automatic snap_t mk(input logic [2:0] st, input logic [3:0] en, input logic [3:0] dr,
                               input logic ar, input logic f, input logic [1:0] fi);
    snap_t s;
    s.st = st; s.en = en; s.dr = dr; s.ar = ar; s.f = f; s.fi = fi;
    return s;
  endfunction

  function automatic logic [3:0] en_mask(input int n);
    logic [4:0] m;
    m = 5'((1 << n) - 1);
    return m[3:0];
  endfunction

  function automatic logic [3:0] rel_mask(input int k);
    logic [7:0] m;
    m = 8'h0F << (k + 1);
    return m[3:0];
  endfunction

  function automatic int at(input int t0, input int k);
    return t0 + 1 + k;
  endfunction

  task automatic push(input snap_t s, input int c, input bit wm, input int tag);
    exp_t e;
    e.s = s; e.cyc = c; e.wm = wm; e.tag = tag;
    q.push_back(e);
  endtask

  // Queue the bring-up: domain d enters PLL_ON at p[d], WAIT_LOCK at p[d]+1, STABLE at p[d]+14.
  task automatic push_bringup(input int t0, input int p2, input int p3, input bit glitch,
                              input int ndom, input int nrel, input int tag);
    int p[4];
    int r;
    p[0] = 0; p[1] = 22; p[2] = p2; p[3] = p3;
    for (int d = 0; d < ndom; d++) begin
      push(mk(3'd1, en_mask(d), 4'hF, 1'b0, 1'b0, 2'd0), at(t0, p[d]), 1'b0, tag);
      push(mk(3'd2, en_mask(d + 1), 4'hF, 1'b0, 1'b0, 2'd0), at(t0, p[d] + 1), 1'b0, tag);
      push(mk(3'd3, en_mask(d + 1), 4'hF, 1'b0, 1'b0, 2'd0), at(t0, p[d] + 14), 1'b0, tag);
      if (glitch && d == 1) begin
        push(mk(3'd2, 4'h3, 4'hF, 1'b0, 1'b0, 2'd0), at(t0, 42), 1'b0, tag);
        push(mk(3'd3, 4'h3, 4'hF, 1'b0, 1'b0, 2'd0), at(t0, 43), 1'b0, tag);
      end
    end
    r = p[3] + 22;
    for (int k = 0; k < nrel && k < 4; k++)
      push(mk(3'd4, 4'hF, rel_mask(k), 1'b0, 1'b0, 2'd0), at(t0, r + 4 * k), 1'b0, tag);
    if (nrel > 4)
      push(mk(3'd5, 4'hF, 4'h0, 1'b1, 1'b0, 2'd0), at(t0, r + 16), 1'b0, tag);
  endtask

  // Monitor: on every output change, pop and compare the next expected snapshot.
  initial begin
    snap_t prev;
    snap_t cur;
    exp_t  e;
    prev = 'x;
    forever begin
      @(negedge clk or posedge rst);
      if (rst) #1;
      cur = mk(state_o, pll_en, domain_rst, all_ready, fault, fault_idx);
      if (cur !== prev) begin
        prev = cur;
        if (q.size() == 0) begin
          checks++; failures++;
          $display("FAIL unexpected_change cyc=%0d got st=%0d en=%h dr=%h ar=%b f=%b fi=%0d",
                   cyc, cur.st, cur.en, cur.dr, cur.ar, cur.f, cur.fi);
        end else if (q[0].wm && (q[0].s !== cur)) begin
          // waiting for a specific snapshot; intermediate changes are not checked
        end else begin
          e = q.pop_front();
          checks++;
          if (e.s !== cur) begin
            failures++;
            $display("FAIL snapshot tag=%0d cyc=%0d got st=%0d en=%h dr=%h ar=%b f=%b fi=%0d exp st=%0d en=%h dr=%h ar=%b f=%b fi=%0d",
                     e.tag, cyc, cur.st, cur.en, cur.dr, cur.ar, cur.f, cur.fi,
                     e.s.st, e.s.en, e.s.dr, e.s.ar, e.s.f, e.s.fi);
          end
          if (e.cyc >= 0) begin
            checks++;
            if (cyc != e.cyc) begin
              failures++;
              $display("FAIL timing tag=%0d st=%0d got cyc=%0d exp cyc=%0d", e.tag, cur.st, cyc, e.cyc);
            end
          end
        end
      end
    end
  end

  // Directed stimulus.
  initial begin
    int t0;
    int t1;
    int t2;

    // Power-on reset
    push(mk(3'd0, 4'h0, 4'hF, 1'b0, 1'b0, 2'd0), -1, 1'b0, 0);
    #2 rst = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    repeat (3) @(negedge clk);

    // Full bring-up to RUN
    t0 = cyc;
    push_bringup(t0, 44, 66, 1'b0, 4, 5, 1);
    start = 1'b1;
    repeat (110) @(negedge clk);

    // Lock loss of domain 1 while running
    t1 = cyc;
`ifdef LOCK_LOSS_RECOVERY_EN
    push(mk(3'd1, 4'h0, 4'hF, 1'b0, 1'b0, 2'd0), t1 + 4, 1'b0, 2);
    push(mk(3'd5, 4'hF, 4'h0, 1'b1, 1'b0, 2'd0), -1, 1'b1, 2);
    kill = 4'b0010;
    repeat (6) @(negedge clk);
    kill = 4'b0000;
    repeat (260) @(negedge clk);
`else
    push(mk(3'd6, 4'h0, 4'hF, 1'b0, 1'b1, 2'd1), t1 + 4, 1'b0, 2);
    kill = 4'b0010;
    repeat (8) @(negedge clk);
`endif
    t2 = cyc;
    push(mk(3'd0, 4'h0, 4'hF, 1'b0, 1'b0, 2'd0), t2 + 1, 1'b0, 2);
    start = 1'b0;
    kill = 4'b0000;
    repeat (6) @(negedge clk);

    // Lock timeout on domain 2
    t0 = cyc;
    push_bringup(t0, 44, 66, 1'b0, 2, 0, 3);
    push(mk(3'd1, 4'h3, 4'hF, 1'b0, 1'b0, 2'd0), at(t0, 44), 1'b0, 3);
    push(mk(3'd2, 4'h7, 4'hF, 1'b0, 1'b0, 2'd0), at(t0, 45), 1'b0, 3);
    push(mk(3'd6, 4'h0, 4'hF, 1'b0, 1'b1, 2'd2), at(t0, 109), 1'b0, 3);
    kill = 4'b0100;
    start = 1'b1;
    repeat (112) @(negedge clk);
    t2 = cyc;
    push(mk(3'd0, 4'h0, 4'hF, 1'b0, 1'b0, 2'd0), t2 + 1, 1'b0, 3);
    start = 1'b0;
    kill = 4'b0000;
    repeat (6) @(negedge clk);

    // One-cycle lock glitch on domain 1 at STABLE cnt=5
    t0 = cyc;
    push_bringup(t0, 51, 73, 1'b1, 4, 5, 4);
    start = 1'b1;
    repeat (39) @(negedge clk);
    kill = 4'b0010;
    @(negedge clk);
    kill = 4'b0000;
    repeat (80) @(negedge clk);
    t2 = cyc;
    push(mk(3'd0, 4'h0, 4'hF, 1'b0, 1'b0, 2'd0), t2 + 1, 1'b0, 4);
    start = 1'b0;
    repeat (6) @(negedge clk);

    // start=0 during WAIT_LOCK of domain 1
    t0 = cyc;
    push_bringup(t0, 44, 66, 1'b0, 1, 0, 5);
    push(mk(3'd1, 4'h1, 4'hF, 1'b0, 1'b0, 2'd0), at(t0, 22), 1'b0, 5);
    push(mk(3'd2, 4'h3, 4'hF, 1'b0, 1'b0, 2'd0), at(t0, 23), 1'b0, 5);
    push(mk(3'd0, 4'h0, 4'hF, 1'b0, 1'b0, 2'd0), at(t0, 26), 1'b0, 5);
    start = 1'b1;
    repeat (26) @(negedge clk);
    start = 1'b0;
    repeat (6) @(negedge clk);

    // Asynchronous reset while releasing (domain_rst=C)
    t0 = cyc;
    push_bringup(t0, 44, 66, 1'b0, 4, 2, 6);
    start = 1'b1;
    repeat (94) @(negedge clk);
    #2;
    push(mk(3'd0, 4'h0, 4'hF, 1'b0, 1'b0, 2'd0), cyc, 1'b0, 6);
    rst = 1'b1;
    start = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    repeat (5) @(negedge clk);

    // Anything still queued was never observed
    while (q.size() > 0) begin
      exp_t e;
      e = q.pop_front();
      checks++; failures++;
      $display("FAIL missing tag=%0d exp st=%0d en=%h dr=%h cyc=%0d", e.tag, e.s.st, e.s.en, e.s.dr, e.cyc);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
